// File: rtl/sobel_pkg.sv
// Shared parameters, luma weights and FSM encoding for the gray frame loader feeding sobel_edge.
package sobel_pkg;
    localparam int IMG_W_DEF  = 640;
    localparam int IMG_H_DEF  = 480;
    localparam int PIX_W_DEF  = 8;
    localparam int ADDR_W_DEF = 32;

    // BT.601-style integer weights; they sum to 256 so the >> 8 is the normalisation.
    localparam int LUMA_R   = 77;
    localparam int LUMA_G   = 150;
    localparam int LUMA_B   = 29;
    localparam int LUMA_RND = 128;
    localparam int LUMA_SH  = 8;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
endpackage

// File: rtl/rgb_gray_frame_loader_if.sv
// Frame-loader bus: request/status, RGB read port and gray write port, plus FSM state for debug.
interface rgb_gray_frame_loader_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 32
);
    import sobel_pkg::*;

    // Handshake: no ready anywhere. go is a request sampled only in IDLE or DONE;
    // rd_rgb answers rd_addr in the same cycle; wr_en is a one-cycle strobe with no backpressure.
    logic                go;
    logic [ADDR_W-1:0]   rd_addr;
    logic [3*PIX_W-1:0]  rd_rgb;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [PIX_W-1:0]    wr_pixel;
    logic                busy;
    logic                done;
    logic                sobel_start;
    state_t              state;

    modport master (
        input  go, rd_rgb,
        output rd_addr, wr_en, wr_addr, wr_pixel, busy, done, sobel_start, state
    );

    modport slave (
        output go, rd_rgb,
        input  rd_addr, wr_en, wr_addr, wr_pixel, busy, done, sobel_start, state
    );
endinterface

// File: rtl/rgb_to_luma.sv
// Two-stage luma pipeline: stage 1 registers weighted products, stage 2 rounds and shifts.
module rgb_to_luma
    import sobel_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [3*PIX_W-1:0] in_rgb,
    input  logic [ADDR_W-1:0]  in_addr,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [PIX_W-1:0]   out_pixel
);
    localparam int PROD_W = PIX_W + 8;
    localparam int SUM_W  = PIX_W + 9;

    logic [PIX_W-1:0]  in_r, in_g, in_b;
    logic [PROD_W-1:0] p_r, p_g, p_b;
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [SUM_W-1:0]  sum;

    assign in_r = in_rgb[3*PIX_W-1:2*PIX_W];
    assign in_g = in_rgb[2*PIX_W-1:PIX_W];
    assign in_b = in_rgb[PIX_W-1:0];

    assign sum = SUM_W'(p_r) + SUM_W'(p_g) + SUM_W'(p_b) + SUM_W'(LUMA_RND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            p_r       <= '0;
            p_g       <= '0;
            p_b       <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_pixel <= '0;
        end else begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_addr <= in_addr;
                p_r     <= PROD_W'(LUMA_R * in_r);
                p_g     <= PROD_W'(LUMA_G * in_g);
                p_b     <= PROD_W'(LUMA_B * in_b);
            end
            // Weights sum to 256, so the rounded result always fits in PIX_W bits.
            if (s1_valid) begin
                out_addr  <= s1_addr;
                out_pixel <= PIX_W'(sum >> LUMA_SH);
            end
        end
    end
endmodule

// File: rtl/rgb_gray_frame_loader.sv
// Raster-scans the RGB frame, writes luma into the gray buffer, then starts sobel_edge.
module rgb_gray_frame_loader
    import sobel_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    rgb_gray_frame_loader_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              drain_last;
    logic              busy_r;
    logic              done_r;
    logic              start_r;

    assign bus.rd_addr     = cnt;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.sobel_start = start_r;
    assign bus.state       = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            drain_last <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            start_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.go) begin
                        state   <= READ;
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        start_r <= 1'b0;
                    end
                end
                READ: begin
                    // Counter parks on the last address; it never wraps.
                    if (cnt == LAST_ADDR) begin
                        state      <= DRAIN;
                        drain_last <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        state   <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        start_r <= 1'b1;
                    end else begin
                        drain_last <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rgb_to_luma #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_luma (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state == READ),
        .in_rgb    (bus.rd_rgb),
        .in_addr   (cnt),
        .out_valid (bus.wr_en),
        .out_addr  (bus.wr_addr),
        .out_pixel (bus.wr_pixel)
    );
endmodule

// File: tb/tb_rgb_gray_frame_loader.sv
// Directed bench for rgb_gray_frame_loader on a small 8x4 frame with a write scoreboard.
module tb_rgb_gray_frame_loader;
    import sobel_pkg::*;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 4;
    localparam int N      = IMG_W * IMG_H;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rgb_gray_frame_loader_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

    rgb_gray_frame_loader #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RGB frame memory with combinational read
    logic [23:0] mem [N];
    assign bus.rd_rgb = (bus.rd_addr < ADDR_W'(N)) ? mem[bus.rd_addr[4:0]] : 24'h0;

    // ---------------- scoreboard ----------------
    logic [39:0] exp_q [$];
    logic [39:0] e;
    int checks = 0;
    int errors = 0;
    int wr_total = 0;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] luma_ref(input logic [23:0] rgb);
        int s;
        s = 77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0]) + 128;
        return 8'(s / 256);
    endfunction

    always @(negedge clk) begin
        if (bus.wr_en) begin
            wr_total++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", bus.wr_en, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.wr_addr, e[39:8]);
                check("wr_pixel", bus.wr_pixel, e[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_uniform(input logic [7:0] v);
        for (int k = 0; k < N; k++) begin
            mem[k] = {v, v, v};
            exp_q.push_back({32'(k), v});
        end
    endtask

    task automatic load_directed();
        logic [23:0] px [4];
        logic [7:0]  ex [4];
        px = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
        ex = '{8'd77, 8'd149, 8'd29, 8'd255};
        for (int k = 0; k < N; k++) begin
            mem[k] = (k < 4) ? px[k] : 24'h000000;
            exp_q.push_back({32'(k), (k < 4) ? ex[k] : 8'd0});
        end
    endtask

    task automatic load_random();
        for (int k = 0; k < N; k++) begin
            mem[k] = 24'($urandom_range(0, 24'hFFFFFF));
            exp_q.push_back({32'(k), luma_ref(mem[k])});
        end
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_rd_addr"}, bus.rd_addr, 0);
        check({tag, "_wr_en"}, bus.wr_en, 0);
        check({tag, "_wr_addr"}, bus.wr_addr, 0);
        check({tag, "_wr_pixel"}, bus.wr_pixel, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_sobel_start"}, bus.sobel_start, 0);
        check({tag, "_state"}, bus.state, IDLE);
    endtask

    // Pulse go, then watch one frame until a few cycles past done (bounded).
    task automatic run_frame(input bit mid_go, output int busy_n, output int done_n,
                             output int first_wr, output int wr_n);
        int wr0;
        int c;
        int tail;
        busy_n = 0; done_n = 0; first_wr = -1; tail = 0;
        wr0 = wr_total;
        @(negedge clk); bus.go = 1'b1;
        @(negedge clk); bus.go = 1'b0;
        c = 0;
        while (c < 4 * N && tail < 3) begin
            if (c == 0) begin
                check("first_rd_addr", bus.rd_addr, 0);
                check("start_low_in_read", bus.sobel_start, 0);
                check("state_read", bus.state, READ);
            end
            if (bus.busy) busy_n++;
            if (bus.wr_en && first_wr < 0) first_wr = c;
            if (bus.done) begin
                done_n++;
                check("busy_low_at_done", bus.busy, 0);
                check("start_at_done", bus.sobel_start, 1);
            end
            if (done_n > 0) tail++;
            bus.go = (mid_go && c == 10);
            @(negedge clk);
            c++;
        end
        wr_n = wr_total - wr0;
    endtask

    task automatic frame_checks(input string tag, input int busy_n, input int done_n,
                                input int first_wr, input int wr_n);
        check({tag, "_busy_cycles"}, busy_n, N + 2);
        check({tag, "_done_pulses"}, done_n, 1);
        check({tag, "_first_wr_latency"}, first_wr, 2);
        check({tag, "_write_count"}, wr_n, N);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_start_hold"}, bus.sobel_start, 1);
        check({tag, "_state_done"}, bus.state, DONE);
        check({tag, "_rd_addr_parked"}, bus.rd_addr, N - 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int busy_n, done_n, first_wr, wr_n, c, wr0;
        rst = 1'b1;
        bus.go = 1'b0;
        for (int k = 0; k < N; k++) mem[k] = 24'h0;
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_go_busy", bus.busy, 0);

        // uniform gray frame
        load_uniform(8'd100);
        run_frame(1'b0, busy_n, done_n, first_wr, wr_n);
        frame_checks("uniform", busy_n, done_n, first_wr, wr_n);
        check("wr_pixel_holds", bus.wr_pixel, 100);
        check("wr_en_idle", bus.wr_en, 0);

        // single-pixel corners, launched from DONE
        load_directed();
        run_frame(1'b0, busy_n, done_n, first_wr, wr_n);
        frame_checks("directed", busy_n, done_n, first_wr, wr_n);

        // go pulsed mid-READ must be ignored
        load_random();
        run_frame(1'b1, busy_n, done_n, first_wr, wr_n);
        frame_checks("mid_go", busy_n, done_n, first_wr, wr_n);

        // asynchronous reset in the middle of a frame
        load_random();
        @(negedge clk); bus.go = 1'b1;
        @(negedge clk); bus.go = 1'b0;
        c = 0;
        while (bus.rd_addr != 20 && c < 4 * N) begin
            @(negedge clk);
            c++;
        end
        check("reached_pixel_20", bus.rd_addr, 20);
        #1 rst = 1'b1;
        exp_q.delete();
        #1 outputs_zero("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wr0 = wr_total;
        repeat (8) @(negedge clk);
        check("no_write_after_rst", wr_total - wr0, 0);
        check("idle_after_rst", bus.state, IDLE);

        // rescan after reset starts from address 0
        load_random();
        run_frame(1'b0, busy_n, done_n, first_wr, wr_n);
        frame_checks("after_rst", busy_n, done_n, first_wr, wr_n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
